// File: rtl/mips_pipe_pkg.sv
// Shared constants and encodings for the MIPS pipeline stages.
// Used by the D->E register, the extender and the controller.
package mips_pipe_pkg;

   localparam int          TNEW_W_DEF   = 2;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'b00,
      EXT_SIGN = 2'b01,
      EXT_LUI  = 2'b10
   } ext_op_e;

   // next-state select shared by every flat field of a pipe register
   typedef enum logic [1:0] {
      SEL_LOAD,
      SEL_HOLD,
      SEL_BUBBLE,
      SEL_RESET
   } pipe_sel_e;

endpackage

// File: rtl/tnew_counter.sv
// Tnew register for the E stage: load, hold-countdown or clear,
// always decrementing with a floor of zero.
module tnew_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
      return (v == '0) ? '0 : v - W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (hold)
         q <= sat_dec(q);
      else if (clear)
         q <= '0;
      else
         q <= sat_dec(d);
   end

endmodule

// File: rtl/id_ex_reg.sv
// D->E pipeline register with bubble insertion, E-stage hold and Tnew countdown.
// Define ID_EX_PERF_EN to add the bubble_cnt performance counter.
module id_ex_reg
   import mips_pipe_pkg::*;
#(
   parameter int          TNEW_W   = TNEW_W_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_hold,
   input  logic              fwd_rs_en,
   input  logic [31:0]       fwd_rs_data,
   input  logic              fwd_rt_en,
   input  logic [31:0]       fwd_rt_data,
   input  logic [31:0]       instr_d,
   input  logic [31:0]       pc8_d,
   input  logic [31:0]       rs_d,
   input  logic [31:0]       rt_d,
   input  logic [31:0]       ext32_d,
   input  logic [4:0]        a3_d,
   input  logic [TNEW_W-1:0] tnew_d,
   output logic [31:0]       instr_e,
   output logic [31:0]       pc8_e,
   output logic [31:0]       rs_e,
   output logic [31:0]       rt_e,
   output logic [31:0]       ext32_e,
   output logic [4:0]        a3_e,
   output logic [TNEW_W-1:0] tnew_e,
   output logic              bubble_e
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]       bubble_cnt
`endif
);

   pipe_sel_e         sel;
   logic [TNEW_W-1:0] tnew_ld;

   always_comb begin
      sel = SEL_LOAD;
      priority case (1'b1)
         reset:         sel = SEL_RESET;
         ex_hold:       sel = SEL_HOLD;
         stall | flush: sel = SEL_BUBBLE;
         default:       sel = SEL_LOAD;
      endcase
   end

   // no destination register means no producer to wait for
   assign tnew_ld = (a3_d == 5'd0) ? '0 : tnew_d;

   tnew_counter #(.W(TNEW_W)) u_tnew (
      .clk   (clk),
      .reset (reset),
      .hold  (ex_hold),
      .clear (stall | flush),
      .d     (tnew_ld),
      .q     (tnew_e)
   );

   always_ff @(posedge clk) begin
      case (sel)
         SEL_RESET, SEL_BUBBLE: begin
            instr_e  <= NOP_INSTR;
            pc8_e    <= RESET_PC;
            rs_e     <= '0;
            rt_e     <= '0;
            ext32_e  <= '0;
            a3_e     <= '0;
            bubble_e <= (sel == SEL_BUBBLE);
         end
         SEL_HOLD: begin
            if (fwd_rs_en)
               rs_e <= fwd_rs_data;
            if (fwd_rt_en)
               rt_e <= fwd_rt_data;
         end
         SEL_LOAD: begin
            instr_e  <= instr_d;
            pc8_e    <= pc8_d;
            rs_e     <= rs_d;
            rt_e     <= rt_d;
            ext32_e  <= ext32_d;
            a3_e     <= a3_d;
            bubble_e <= 1'b0;
         end
      endcase
   end

`ifdef ID_EX_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)
         bubble_cnt <= '0;
      else if (sel == SEL_BUBBLE)
         bubble_cnt <= bubble_cnt + 32'd1;
   end
`endif

endmodule
